// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;
   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;
endpackage

// File: rtl/muldiv_addsub.sv
// Combinational W-bit add/subtract; cout_o is carry for add, not-borrow for subtract.
module muldiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);
   logic [W:0] res;

   assign res = {1'b0, a_i} + {1'b0, b_i ^ {W{sub_i}}} + {{W{1'b0}}, sub_i};
   assign {cout_o, sum_o} = res;
endmodule

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO; 34-cycle latency, magnitude arithmetic.
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_WRITE_EN.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MULDIV_HILO_WRITE_EN
   input  logic [1:0]       hilo_we,
   input  logic [WIDTH-1:0] hilo_wdata,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int W = WIDTH;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [W-1:0]       araw_q, araw_d;
   logic [W-1:0]       bop_q, bop_d;
   logic [W-1:0]       rem_q, rem_d;
   logic [W-1:0]       acc_q, acc_d;
   logic [W-1:0]       hi_q, hi_d;
   logic [W-1:0]       lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic [W:0] x0_a, x0_b, x0_sum, x1_a, x1_b, x1_sum;
   logic       x0_sub, x0_c, x1_sub, x1_c;
   logic       sa, sb;
   logic       unused_bits;

   // x0 is the iteration datapath; x1 handles |b| in IDLE and the upper word in FIX.
   muldiv_addsub #(.W(W+1)) u_as0 (
      .a_i(x0_a), .b_i(x0_b), .sub_i(x0_sub), .sum_o(x0_sum), .cout_o(x0_c)
   );
   muldiv_addsub #(.W(W+1)) u_as1 (
      .a_i(x1_a), .b_i(x1_b), .sub_i(x1_sub), .sum_o(x1_sum), .cout_o(x1_c)
   );

   assign unused_bits = ^{x1_c, x1_sum[W]};
   assign sa          = ~op[0] & a[W-1];
   assign sb          = ~op[0] & b[W-1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      araw_d   = araw_q;
      bop_d    = bop_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = 1'b0;
      x0_a     = '0;
      x0_b     = '0;
      x0_sub   = 1'b0;
      x1_a     = '0;
      x1_b     = '0;
      x1_sub   = 1'b0;
      case (state_q)
         IDLE: begin
            x0_b   = {1'b0, a};
            x0_sub = 1'b1;
            x1_b   = {1'b0, b};
            x1_sub = 1'b1;
`ifdef MULDIV_HILO_WRITE_EN
            if (hilo_we[1]) hi_d = hilo_wdata;
            if (hilo_we[0]) lo_d = hilo_wdata;
`endif
            if (start) begin
               is_div_d = op[1];
               neg_d    = sa ^ sb;
               rneg_d   = sa;
               araw_d   = a;
               acc_d    = sa ? x0_sum[W-1:0] : a;
               bop_d    = sb ? x1_sum[W-1:0] : b;
               rem_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (is_div_q) begin
               // Restoring step: keep the difference only when it did not borrow.
               x0_a   = {rem_q, acc_q[W-1]};
               x0_b   = {1'b0, bop_q};
               x0_sub = 1'b1;
               rem_d  = x0_c ? x0_sum[W-1:0] : x0_a[W-1:0];
               acc_d  = {acc_q[W-2:0], x0_c};
            end else begin
               x0_a  = {1'b0, rem_q};
               x0_b  = acc_q[0] ? {1'b0, bop_q} : '0;
               rem_d = x0_sum[W:1];
               acc_d = {x0_sum[0], acc_q[W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W-1)) state_d = FIX;
         end
         FIX: begin
            x0_b   = {1'b0, acc_q};
            x0_sub = 1'b1;
            // Product upper word is ~hi plus the carry out of negating the lower word.
            x1_a   = (!is_div_q && !x0_c) ? {1'b0, {W{1'b1}}} : '0;
            x1_b   = {1'b0, rem_q};
            x1_sub = 1'b1;
            if (is_div_q && bop_q == '0) begin
               hi_d  = araw_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               lo_d = neg_q ? x0_sum[W-1:0] : acc_q;
               hi_d = (is_div_q ? rneg_q : neg_q) ? x1_sum[W-1:0] : rem_q;
            end
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         araw_q   <= '0;
         bop_q    <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         araw_q   <= araw_d;
         bop_q    <= bop_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == CALC) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected HI/LO/flag, monitor checks on done.
module tb_muldiv_unit;
   import muldiv_pkg::*;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, dbz;
   logic [W-1:0] hi, lo;
`ifdef MULDIV_HILO_WRITE_EN
   logic [1:0]   hilo_we    = '0;
   logic [W-1:0] hilo_wdata = '0;
`endif

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_HILO_WRITE_EN
      .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
`endif
      .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           t0;
      string        name;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: done must come 33 edges after the start-sampling edge.
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no done at cyc %0d", cyc);
            end else begin
               e = sbq.pop_front();
               chk({e.name, ".lat"}, W'(cyc - e.t0), W'(33));
               chk({e.name, ".hi"}, hi, e.hi);
               chk({e.name, ".lo"}, lo, e.lo);
               chk({e.name, ".dbz"}, W'(dbz), W'(e.dbz));
            end
         end else if (dbz) begin
            checks++;
            errors++;
            $display("FAIL dbz_without_done: got dbz=1 expected 0 at cyc %0d", cyc);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                        input string nm);
      exp_t x;
      @(negedge clk);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x.hi = ehi; x.lo = elo; x.dbz = edbz; x.t0 = cyc; x.name = nm;
      sbq.push_back(x);
      chk({nm, ".busy"}, W'(busy), W'(1));
   endtask

   task automatic wait_done(input string nm);
      bit got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s.timeout: got no done expected done within 60 cycles", nm);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                      input string nm);
      issue(o, av, bv, ehi, elo, edbz, nm);
      wait_done(nm);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #12;
      chk("rst.busy", W'(busy), W'(0));
      chk("rst.done", W'(done), W'(0));
      chk("rst.dbz", W'(dbz), W'(0));
      chk("rst.hi", hi, 32'h0);
      chk("rst.lo", lo, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
      run(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_neg");
      run(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
      run(OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_zero");
      run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
      run(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu_rem");

      repeat (5) @(negedge clk);
      chk("hold.hi", hi, 32'd2);
      chk("hold.lo", lo, 32'd14);

      // A second start while busy must not disturb the operation in flight.
      issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "multu_restart");
      repeat (9) @(negedge clk);
      op = OP_MULTU; a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("multu_restart");

      // Reset mid-operation: abandoned, nothing queued, no done may appear.
      @(negedge clk);
      op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst.busy", W'(busy), W'(0));
      chk("midrst.done", W'(done), W'(0));
      chk("midrst.hi", hi, 32'h0);
      chk("midrst.lo", lo, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("midrst.hi_after", hi, 32'h0);
      chk("sb.empty", W'(sbq.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS datapath. Implements MULT, MULTU, DIV and DIVU and owns the HI/LO register pair.
- Sits beside the ALU in EX. It is fed the same rs/rt operands, and its iteration datapath is the 33-bit add/sub that the ALU adder already provides.
- The controller stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand: multiplicand or dividend.
- b  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO valid from this cycle.
- div_by_zero  output  1  pulses with done when a divide had b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On start=1, latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned ops).
  - Latch result signs: quotient/product sign = sa^sb; remainder sign = sa.
  - Clear the accumulator, counter=0, go to CALC.
- CALC: exactly WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add, radix-2, LSB-first on a 2*WIDTH accumulator.
  - Divide: restoring. Remainder register is WIDTH+1 bits; each step shifts left and subtracts the divisor; if the result is non-negative, keep it and set quotient bit=1, otherwise restore and set 0.
- FIX (1 cycle): two's-complement negate the product, quotient and/or remainder per the latched signs.
- DONE (1 cycle):
  - hi/lo are written at the edge entering DONE; done=1 and busy=0 in DONE.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - The state then returns to IDLE.
- Latency: start sampled at edge N; busy=1 for cycles N+1..N+33; done=1 in cycle N+34.
- Back-to-back: start is ignored in DONE and must be re-asserted in IDLE. Minimum issue interval is 35 cycles.
- start while busy or in DONE: ignored; latched operands are unchanged.
- Divide by zero:
  - Full latency is still taken.
  - Result: hi=a (original operand), lo={WIDTH{1'b1}}, div_by_zero=1 in the DONE cycle.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag. This falls out of the magnitude arithmetic: the 2^31 magnitude negates back to 0x80000000.
- hi/lo hold their values between operations and are changed only at the DONE transition (or by the optional write port).
- Reset mid-CALC or mid-FIX: the operation is abandoned, hi/lo=0, and no done pulse is produced.

Optional Feature:
- Macro: MULDIV_HILO_WRITE_EN.
- Defined:
  - Adds inputs hilo_we[1:0] (bit1=HI, bit0=LO) and hilo_wdata[WIDTH-1:0] for MTHI/MTLO.
  - A write in IDLE updates the selected register at the next edge.
  - Writes are ignored while busy or in DONE.
  - If start and hilo_we are both asserted in IDLE, the write lands and the operation also starts; its result later overwrites HI/LO.
- Undefined: no extra ports; HI/LO are written only by completed operations.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum IDLE/CALC/FIX/DONE;
  - WIDTH default.
- One sub-module, muldiv_addsub: combinational (WIDTH+1)-bit adder/subtractor with sub select, sum and carry/borrow out. It is shared by the multiply add step, the divide subtract step and the FIX negation.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 with done only.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MULTU 6*7 with start re-pulsed at cycle 10 (a=1 b=1) -> ignored, lo=42. A second run with rst at cycle 20 -> busy=0, hi=lo=0 immediately, no done pulse.
